// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared states and constants for the PIC host bus initiator
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_RECOV,
    ST_ACK_LO,
    ST_ACK_GAP
  } pic_state_e;

  localparam int         ICW1_INIT_BIT = 4;
  localparam logic [7:0] MCS80_CALL_OP = 8'hCD;
  localparam int         ACK_N_8086    = 2;
  localparam int         ACK_N_8080    = 3;

endpackage

// File: rtl/pic_strobe_timer.sv
// rtl/pic_strobe_timer.sv - loadable down-counter timing strobe, recovery and INTA phases
module pic_strobe_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load N-1 on phase entry, then count down and park at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pic_host_master.sv
// rtl/pic_host_master.sv - 8259A-style PIC bus initiator; PIC_MCS80_MODE_EN selects 3-byte 8080 acknowledge
module pic_host_master
  import pic_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int RECOV_CYC  = 2,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic        cmd_a0,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic        irq_en,
  output logic        vec_valid,
  output logic [15:0] vec_data,
  output logic        busy,
  inout  wire  [7:0]  D,
  output logic        NCS,
  output logic        NRD,
  output logic        NWR,
  output logic        NINTA,
  output logic        A0,
  input  logic        INT
`ifdef PIC_MCS80_MODE_EN
  ,
  output logic        call_err
`endif
);

`ifdef PIC_MCS80_MODE_EN
  localparam int ACK_N = ACK_N_8080;
`else
  localparam int ACK_N = ACK_N_8086;
`endif
  localparam logic [1:0]       ACK_LAST = 2'(ACK_N);
  localparam logic [CNT_W-1:0] STRB_LD  = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC - 1);

  pic_state_e       state_q, state_d;
  logic [1:0]       ack_idx_q, ack_idx_d;
  logic             int_meta_q, int_sync_q;
  logic             rd_q, a0_q;
  logic [7:0]       wdata_q;
  logic             rsp_valid_q, vec_valid_q;
  logic [7:0]       rsp_data_q;
  logic [15:0]      vec_data_q;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic             ack_start, accept, sample_rd, sample_ack, d_oe;
`ifdef PIC_MCS80_MODE_EN
  logic             mismatch_q, call_err_q;
  logic [7:0]       vec_lo_q;
`endif

  pic_strobe_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign ack_start  = int_sync_q && irq_en;
  assign cmd_ready  = !reset && (state_q == ST_IDLE) && !ack_start;
  assign accept     = cmd_valid && cmd_ready;
  assign sample_rd  = (state_q == ST_STRB) && tmr_done && rd_q;
  assign sample_ack = (state_q == ST_ACK_LO) && tmr_done;

  // Two-flop synchroniser for the asynchronous INT request
  always_ff @(posedge clk) begin
    if (reset) begin
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_sync_q <= int_meta_q;
    end
  end

  // State and acknowledge-index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ack_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      ack_idx_q <= ack_idx_d;
    end
  end

  // Next-state logic; every timed phase loads the shared timer on entry
  always_comb begin
    state_d   = state_q;
    ack_idx_d = ack_idx_q;
    tmr_load  = 1'b0;
    tmr_val   = STRB_LD;
    case (state_q)
      ST_IDLE: begin
        if (ack_start) begin
          state_d   = ST_ACK_LO;
          ack_idx_d = 2'd1;
          tmr_load  = 1'b1;
        end else if (accept) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d  = ST_STRB;
        tmr_load = 1'b1;
      end
      ST_STRB: begin
        if (tmr_done) begin
          state_d  = ST_RECOV;
          tmr_load = 1'b1;
          tmr_val  = RECOV_LD;
        end
      end
      ST_RECOV: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      ST_ACK_LO: begin
        if (tmr_done) begin
          state_d  = (ack_idx_q < ACK_LAST) ? ST_ACK_GAP : ST_RECOV;
          tmr_load = 1'b1;
          tmr_val  = RECOV_LD;
        end
      end
      ST_ACK_GAP: begin
        if (tmr_done) begin
          state_d   = ST_ACK_LO;
          ack_idx_d = ack_idx_q + 2'd1;
          tmr_load  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, read-data capture and vector assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q        <= 1'b0;
      a0_q        <= 1'b0;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      vec_valid_q <= 1'b0;
      vec_data_q  <= 16'h0000;
`ifdef PIC_MCS80_MODE_EN
      mismatch_q  <= 1'b0;
      call_err_q  <= 1'b0;
      vec_lo_q    <= 8'h00;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      vec_valid_q <= 1'b0;
`ifdef PIC_MCS80_MODE_EN
      call_err_q  <= 1'b0;
`endif
      if (accept) begin
        rd_q    <= cmd_rd;
        a0_q    <= cmd_a0;
        wdata_q <= cmd_data;
      end
      if (sample_rd) begin
        rsp_data_q  <= D;
        rsp_valid_q <= 1'b1;
      end
      if (sample_ack) begin
`ifdef PIC_MCS80_MODE_EN
        if (ack_idx_q == 2'd1) mismatch_q <= (D != MCS80_CALL_OP);
        if (ack_idx_q == 2'd2) vec_lo_q <= D;
        if (ack_idx_q == ACK_LAST) begin
          vec_data_q  <= {D, vec_lo_q};
          vec_valid_q <= 1'b1;
          call_err_q  <= mismatch_q;
        end
`else
        // First INTA byte is a dummy cycle in 8086 mode and is dropped
        if (ack_idx_q == ACK_LAST) begin
          vec_data_q  <= {8'h00, D};
          vec_valid_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign d_oe      = ((state_q == ST_ADDR) || (state_q == ST_STRB)) && !rd_q;
  assign D         = d_oe ? wdata_q : 8'hzz;
  assign NCS       = !((state_q == ST_ADDR) || (state_q == ST_STRB));
  assign NWR       = !((state_q == ST_STRB) && !rd_q);
  assign NRD       = !((state_q == ST_STRB) && rd_q);
  assign NINTA     = (state_q != ST_ACK_LO);
  assign A0        = a0_q;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
`ifdef PIC_MCS80_MODE_EN
  assign call_err  = call_err_q;
`endif

endmodule

// File: tb/tb_pic_host_master.sv
// tb/tb_pic_host_master.sv - directed scoreboard bench for pic_host_master
module tb_pic_host_master;

  localparam logic [7:0] KEEP = 8'h5A;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_rd, cmd_a0, irq_en, INT;
  logic [7:0]  cmd_data;
  logic        cmd_ready, rsp_valid, vec_valid, busy;
  logic [7:0]  rsp_data;
  logic [15:0] vec_data;
  logic        NCS, NRD, NWR, NINTA, A0;
  wire  [7:0]  D;
  logic        call_err;

  always #5 clk = ~clk;

  pic_host_master dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd    (cmd_rd),
    .cmd_a0    (cmd_a0),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .irq_en    (irq_en),
    .vec_valid (vec_valid),
    .vec_data  (vec_data),
    .busy      (busy),
    .D         (D),
    .NCS       (NCS),
    .NRD       (NRD),
    .NWR       (NWR),
    .NINTA     (NINTA),
    .A0        (A0),
    .INT       (INT)
`ifdef PIC_MCS80_MODE_EN
    ,
    .call_err  (call_err)
`endif
  );

`ifndef PIC_MCS80_MODE_EN
  assign call_err = 1'b0;
`endif

  // PIC-side model: answers reads and INTA pulses, parks the bus on KEEP
  // whenever the DUT must not be driving so any stray drive shows up.
  logic [7:0] rd_byte;
  logic       cur_rd;
  logic [7:0] inta_bytes [3];
  int         inta_seq = 0;
  int         inta_base = 0;
  int         k;
  logic [7:0] inta_byte, d_tb;
  logic       d_tb_oe;

  always @(negedge NINTA) inta_seq++;

  always_comb begin
    k = inta_seq - inta_base - 1;
    inta_byte = 8'hFF;
    if (k >= 0 && k < 3) inta_byte = inta_bytes[k];
    d_tb_oe = 1'b1;
    d_tb    = KEEP;
    if (!NCS) begin
      if (!cur_rd) d_tb_oe = 1'b0;
      else if (!NRD) d_tb = rd_byte;
    end else if (!NINTA) begin
      d_tb = inta_byte;
    end
  end

  assign D = d_tb_oe ? d_tb : 8'hzz;

  // Bus monitor and actual-result capture
  int ncs_low_n = 0, nwr_low_n = 0, nrd_low_n = 0, a0_rd_n = 0;
  int d_match_n = 0, d_bad_rd_n = 0, adr_keep_n = 0, vec_n = 0;
  longint rsp_t = 0, vec_t = 0;
  logic [7:0]  exp_wd;
  logic [31:0] got_rsp[$], got_vec[$], exp_rsp[$], exp_vec[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (!NCS) ncs_low_n++;
      if (!NWR) nwr_low_n++;
      if (!NRD) begin
        nrd_low_n++;
        if (A0) a0_rd_n++;
        if (D !== rd_byte) d_bad_rd_n++;
      end
      if (!NCS && D === exp_wd) d_match_n++;
      if (!NCS && NRD && NWR && D === KEEP) adr_keep_n++;
      if (rsp_valid) begin
        rsp_t = $time;
        got_rsp.push_back({24'h0, rsp_data});
      end
      if (vec_valid) begin
        vec_n++;
        vec_t = $time;
        got_vec.push_back({15'h0, call_err, vec_data});
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_rsp(input string tag);
    chk({tag, "_rsp_count"}, got_rsp.size(), exp_rsp.size());
    while (got_rsp.size() > 0 && exp_rsp.size() > 0)
      chk({tag, "_rsp_data"}, got_rsp.pop_front(), exp_rsp.pop_front());
    got_rsp.delete();
    exp_rsp.delete();
  endtask

  task automatic drain_vec(input string tag);
    chk({tag, "_vec_count"}, got_vec.size(), exp_vec.size());
    while (got_vec.size() > 0 && exp_vec.size() > 0)
      chk({tag, "_vec_data"}, got_vec.pop_front(), exp_vec.pop_front());
    got_vec.delete();
    exp_vec.delete();
  endtask

  task automatic wait_accept(input string tag);
    int i;
    for (i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        tick();
        break;
      end
      tick();
    end
    if (i == 200) chk({tag, "_accept_timeout"}, 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat, output int rlat);
    lat  = 0;
    rlat = 0;
    do begin
      tick();
      lat++;
      if (rsp_valid && rlat == 0) rlat = lat;
    end while (!cmd_ready && lat < 200);
    if (lat >= 200) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic do_cmd(input string tag, input logic rd, input logic a0, input logic [7:0] data,
                        output int lat, output int rlat);
    cur_rd    = rd;
    cmd_rd    = rd;
    cmd_a0    = a0;
    cmd_data  = data;
    cmd_valid = 1'b1;
    wait_accept(tag);
    wait_done(tag, lat, rlat);
  endtask

  task automatic wait_ninta_low(input string tag);
    int i;
    for (i = 0; i < 100 && NINTA !== 1'b0; i++) tick();
    if (i == 100) chk({tag, "_ninta_timeout"}, 0, 1);
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (NINTA === lvl && n < 50) begin
      n++;
      tick();
    end
  endtask

  int lat, rlat, l1, g, l2;
  int s_ncs, s_nwr, s_nrd, s_a0, s_dm, s_dbad, s_akeep, s_vec, s_seq;

  task automatic snap();
    s_ncs = ncs_low_n; s_nwr = nwr_low_n; s_nrd = nrd_low_n; s_a0 = a0_rd_n;
    s_dm = d_match_n; s_dbad = d_bad_rd_n; s_akeep = adr_keep_n; s_vec = vec_n;
    s_seq = inta_seq;
    inta_base = inta_seq;
  endtask

  task automatic run_ack(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [31:0] expv, input int pulses);
    snap();
    inta_bytes[0] = b0; inta_bytes[1] = b1; inta_bytes[2] = b2;
    exp_vec.push_back(expv);
    INT = 1'b1;
    wait_ninta_low(tag);
    INT = 1'b0;
    for (int i = 0; i < 100 && busy; i++) tick();
    repeat (6) tick();
    chk({tag, "_pulses"}, inta_seq - s_seq, pulses);
    chk({tag, "_ncs_low"}, ncs_low_n - s_ncs, 0);
    chk({tag, "_vec_once"}, vec_n - s_vec, 1);
    drain_vec(tag);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
    irq_en = 1'b0; INT = 1'b0; rd_byte = 8'h00; cur_rd = 1'b0; exp_wd = 8'h00;
    inta_bytes[0] = 8'hFF; inta_bytes[1] = 8'hFF; inta_bytes[2] = 8'hFF;

    // Reset values
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    tick();
    chk("rst_cmd_ready_after", cmd_ready, 1);
    chk("rst_ncs", NCS, 1);
    chk("rst_nrd", NRD, 1);
    chk("rst_nwr", NWR, 1);
    chk("rst_ninta", NINTA, 1);
    chk("rst_a0", A0, 0);
    chk("rst_d_released", {24'h0, D}, {24'h0, KEEP});
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_vec_data", vec_data, 0);
    chk("rst_busy", busy, 0);

    // Write cycle: A0=0, data 13
    snap();
    exp_wd = 8'h13;
    do_cmd("wr", 1'b0, 1'b0, 8'h13, lat, rlat);
    chk("wr_latency", lat, 5);
    chk("wr_ncs_low", ncs_low_n - s_ncs, 3);
    chk("wr_nwr_low", nwr_low_n - s_nwr, 2);
    chk("wr_nrd_low", nrd_low_n - s_nrd, 0);
    chk("wr_d_held", d_match_n - s_dm, 3);
    chk("wr_d_released", {24'h0, D}, {24'h0, KEEP});
    drain_rsp("wr");

    // Read cycle: A0=1, PIC returns A5
    snap();
    rd_byte = 8'hA5;
    exp_rsp.push_back(32'h0000_00A5);
    do_cmd("rd", 1'b1, 1'b1, 8'h00, lat, rlat);
    chk("rd_latency", lat, 5);
    chk("rd_rsp_latency", rlat, 3);
    chk("rd_nrd_low", nrd_low_n - s_nrd, 2);
    chk("rd_nwr_low", nwr_low_n - s_nwr, 0);
    chk("rd_a0_high", a0_rd_n - s_a0, 2);
    chk("rd_d_contention", d_bad_rd_n - s_dbad, 0);
    chk("rd_addr_not_driven", adr_keep_n - s_akeep, 1);
    drain_rsp("rd");
    chk("rd_rsp_data_held", rsp_data, 8'hA5);

    // Interrupt acknowledge, INT dropped during the first pulse
    irq_en = 1'b1;
    snap();
    inta_bytes[0] = 8'hFF; inta_bytes[1] = 8'h48; inta_bytes[2] = 8'hFF;
`ifdef PIC_MCS80_MODE_EN
    inta_bytes[0] = 8'hCD; inta_bytes[1] = 8'h48; inta_bytes[2] = 8'h00;
    exp_vec.push_back(32'h0000_0048);
`else
    exp_vec.push_back(32'h0000_0048);
`endif
    INT = 1'b1;
    wait_ninta_low("ack");
    INT = 1'b0;
    measure(1'b0, l1);
    measure(1'b1, g);
    measure(1'b0, l2);
    chk("ack_pulse1_len", l1, 2);
    chk("ack_gap_len", g, 2);
    chk("ack_pulse2_len", l2, 2);
    for (int i = 0; i < 100 && busy; i++) tick();
    repeat (6) tick();
`ifndef PIC_MCS80_MODE_EN
    chk("ack_pulses", inta_seq - s_seq, 2);
`endif
    chk("ack_ncs_high", ncs_low_n - s_ncs, 0);
    chk("ack_vec_once", vec_n - s_vec, 1);
    drain_vec("ack");

    // INT and cmd_valid in the same IDLE cycle
    snap();
    inta_bytes[0] = 8'hFF; inta_bytes[1] = 8'h33; inta_bytes[2] = 8'h00;
`ifdef PIC_MCS80_MODE_EN
    inta_bytes[0] = 8'hCD;
    exp_vec.push_back(32'h0000_0033);
`else
    inta_bytes[1] = 8'h5A;
    exp_vec.push_back(32'h0000_005A);
`endif
    rd_byte = 8'h3C;
    exp_rsp.push_back(32'h0000_003C);
    cur_rd = 1'b1;
    INT = 1'b1;
    tick();
    tick();
    cmd_rd = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h00; cmd_valid = 1'b1;
    chk("both_cmd_ready_low", cmd_ready, 0);
    wait_ninta_low("both");
    INT = 1'b0;
    wait_accept("both");
    wait_done("both", lat, rlat);
    repeat (2) tick();
    chk("both_ack_first", (vec_t < rsp_t) ? 1 : 0, 1);
    drain_vec("both");
    drain_rsp("both");

    // Reset during STRB of a write, then a clean write
    irq_en = 1'b0;
    exp_wd = 8'h99;
    cur_rd = 1'b0;
    cmd_rd = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'h99; cmd_valid = 1'b1;
    wait_accept("mid");
    tick();
    chk("mid_in_strb", NWR, 0);
    reset = 1'b1;
    tick();
    chk("mid_nwr", NWR, 1);
    chk("mid_ncs", NCS, 1);
    chk("mid_busy", busy, 0);
    chk("mid_a0", A0, 0);
    chk("mid_d_released", {24'h0, D}, {24'h0, KEEP});
    chk("mid_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    tick();
    snap();
    exp_wd = 8'h5C;
    do_cmd("post", 1'b0, 1'b0, 8'h5C, lat, rlat);
    chk("post_latency", lat, 5);
    chk("post_nwr_low", nwr_low_n - s_nwr, 2);
    chk("post_d_held", d_match_n - s_dm, 3);

`ifdef PIC_MCS80_MODE_EN
    irq_en = 1'b1;
    run_ack("mcs_ok", 8'hCD, 8'h20, 8'h00, 32'h0000_0020, 3);
    run_ack("mcs_bad", 8'hCC, 8'h20, 8'h00, 32'h0001_0020, 3);
    irq_en = 1'b0;
`endif

    drain_rsp("final");
    drain_vec("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pic_host_master.md
Name: pic_host_master

Overview:
- CPU-side bus initiator for the 8259A-style PIC: the other end of the PIC's D/NRD/NWR/NCS/A0/NINTA/INT interface.
- Turns single-beat host commands into correctly timed PIC write/read cycles (ICW/OCW programming, status reads).
- On INT, autonomously runs the interrupt-acknowledge pulse sequence and captures the vector byte(s).
- Sits between the system host logic and the PIC top level; used in system integration and as the PIC's bus driver in benches.

Parameters:
- STROBE_CYC, 2: cycles NRD, NWR or NINTA is held low (range 1..15).
- RECOV_CYC, 2: idle cycles after each strobe, all strobes high and NCS high (range 1..15).
- CNT_W, 4: width of the internal strobe/recovery counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high only in IDLE when no acknowledge is starting.
- cmd_rd  in  1  1 = read cycle, 0 = write cycle.
- cmd_a0  in  1  value driven on A0.
- cmd_data  in  8  write data.
- rsp_valid  out  1  one-cycle pulse carrying read data.
- rsp_data  out  8  sampled D; holds its value until the next read.
- irq_en  in  1  enables automatic acknowledge.
- vec_valid  out  1  one-cycle pulse when the vector is captured.
- vec_data  out  16  captured vector; [7:0] is the last INTA byte.
- busy  out  1  high whenever not in IDLE.
- D  inout  8  PIC data bus; driven only during write ADDR/STRB, otherwise Z.
- NCS, NRD, NWR, NINTA  out  1 each  active-low strobes to the PIC.
- A0  out  1  address bit.
- INT  in  1  PIC interrupt request; passed through a 2-flop synchroniser.

Behaviour:
- Reset values:
  - NCS = NRD = NWR = NINTA = 1, A0 = 0, D = Z.
  - cmd_ready = 0 during reset, then 1 the cycle after.
  - rsp_valid = vec_valid = 0, rsp_data = 0, vec_data = 0, busy = 0.
  - State goes to IDLE and all counters clear.
- Reset asserted mid-operation aborts the cycle: the next edge returns every output to its reset value, with no partial pulses held.
- States: IDLE, ADDR, STRB, RECOV, ACK_LO, ACK_GAP.
- Transitions from IDLE:
  - If int_sync && irq_en: go to ACK_LO with ack_idx = 1. The acknowledge wins over a simultaneous cmd_valid, and cmd_ready is 0 in that cycle.
  - Else if cmd_valid && cmd_ready: latch cmd_rd/cmd_a0/cmd_data and go to ADDR.
- ADDR (1 cycle): NCS = 0, A0 = latched value, D driven if write, strobes high.
- STRB (STROBE_CYC cycles): NCS = 0 and NWR or NRD = 0.
  - Read: D is sampled on the last STRB cycle and rsp_valid pulses on the following cycle.
  - Write data is held stable through the whole of STRB.
- RECOV (RECOV_CYC cycles): NCS = 1, strobes high, D = Z; then back to IDLE.
- ACK_LO (STROBE_CYC cycles): NINTA = 0 and NCS = 1; D is sampled on the last cycle.
  - If ack_idx < ACK_N: go to ACK_GAP (RECOV_CYC cycles, NINTA = 1), increment ack_idx, return to ACK_LO.
  - Else: go to RECOV; vec_valid pulses on the cycle after the last sample.
- ACK_N = 2 without the optional feature.
- Vector capture:
  - Sample 1 is discarded (8086 mode).
  - The last sample goes to vec_data[7:0]; vec_data[15:8] = 0.
- If INT drops during an acknowledge, the sequence still completes and the captured byte is reported unchanged.
- INT still high after RECOV starts a new acknowledge; it is not edge-gated.
- Latency:
  - Write: 1 + STROBE_CYC + RECOV_CYC cycles from acceptance to cmd_ready.
  - Read: rsp_valid at acceptance + 1 + STROBE_CYC.
- Counters load (N−1) and count down; the loaded value is compared at zero, so there are no wrap hazards.
- No handshake on rsp_valid or vec_valid; the consumer must take the pulse.

Optional Feature:
- PIC_MCS80_MODE_EN defined: ACK_N = 3 (8080/8085 mode).
  - Byte 1 (CALL opcode 0xCD) is checked; a mismatch still completes the sequence.
  - Byte 2 goes to vec_data[7:0] and byte 3 to vec_data[15:8].
  - Adds output call_err (1 bit), pulsed together with vec_valid on a mismatch.
- Undefined: ACK_N = 2, no call_err port.

Decomposition:
- Package pic_pkg:
  - State enum.
  - ICW1_INIT_BIT = 4.
  - MCS80_CALL_OP = 8'hCD.
  - ACK_N_8086 = 2, ACK_N_8080 = 3.
- Sub-module pic_strobe_timer: loadable down-counter with a done flag, shared by the STRB, RECOV, ACK_LO and ACK_GAP states.
- Synchroniser kept inline.

Test Plan:
- Reset, then write cmd_a0 = 0, cmd_data = 8'h13 with STROBE_CYC = RECOV_CYC = 2 -> NCS low 3 cycles, NWR low exactly 2 cycles, D = 8'h13 throughout, cmd_ready returns after 5 cycles.
- Read with A0 = 1 while the bench drives D = 8'hA5 during NRD low -> rsp_valid one cycle with rsp_data = 8'hA5; D is never driven by the DUT.
- irq_en = 1, INT rises, bench answers the second INTA with 8'h48 -> exactly two NINTA pulses separated by 2 high cycles, NCS stays high, vec_valid once with vec_data = 16'h0048.
- INT and cmd_valid arrive in the same IDLE cycle -> acknowledge runs first and the command is accepted afterwards, without being lost (cmd_valid held).
- reset asserted during STRB of a write -> next cycle NWR = NCS = 1, D = Z, busy = 0; a subsequent command runs normally.
- With PIC_MCS80_MODE_EN: INTA bytes CD/20/00 -> three pulses, vec_data = 16'h0020, call_err = 0; first byte 8'hCC -> call_err pulses.
